timer_scheduler: RTL and testbench

Shares one 5-bit countdown timer between `N_REQ` requesters. Each requester posts a delay over a valid/ready handshake. A round-robin arbiter grants one request at a time. The block counts the delay down and pulses that requester's `done` bit when it expires. It sits between the control FSMs that need timed waits and the single countdown resource, so no requester instantiates its own timer.

---
 rtl/timer_sched_pkg.sv | 6 +
 rtl/timer_scheduler_rr_arbiter.sv | 23 ++
 rtl/timer_scheduler.sv | 70 +++++++
 tb/tb_timer_scheduler.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared state encoding and default sizing for the timer scheduler
package timer_sched_pkg;
  typedef enum logic {IDLE, COUNT} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int W_DEF = 5;
endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr and wrapping
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int PW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx
);
  // scan from farthest to nearest so the requester closest to ptr is written last and wins
  always_comb begin
    gnt = '0;
    idx = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N_REQ]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N_REQ] = 1'b1;
        idx = PW'((int'(ptr) + i) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: one shared countdown timer granted round-robin to N_REQ requesters
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W = W_DEF,
  localparam int PW = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ*W-1:0] req_delay,
  output logic [N_REQ-1:0] req_ready,
  input  logic             abort,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic [PW-1:0]    owner
);
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, sel_delay;
  logic [PW-1:0] ptr_q, owner_q, gnt_idx, next_ptr;
  logic [N_REQ-1:0] gnt, done_q;
  logic accept, expire;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(gnt_idx)
  );

  assign sel_delay = req_delay[gnt_idx*W +: W];
  assign accept = (state_q == IDLE) && |gnt;
  assign expire = (state_q == COUNT) && !abort && cnt_q == '0;
  assign next_ptr = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
  assign done = done_q;
  assign owner = owner_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // next state: abort outranks expiry, both return to IDLE
  always_comb begin
    state_d = (state_q == IDLE) ? (accept ? COUNT : IDLE) : ((abort || cnt_q == '0) ? IDLE : COUNT);
  end

  // outputs: grants only offered while idle
  always_comb begin
    req_ready = (state_q == IDLE) ? gnt : '0;
    busy = state_q == COUNT;
  end

  // counter, pointer, owner and registered done pulse; a 0 delay wraps to a full 2^W count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ptr_q <= '0;
      owner_q <= '0;
      done_q <= '0;
    end else begin
      cnt_q <= accept ? sel_delay - W'(1) : ((state_q == COUNT) ? cnt_q - W'(1) : cnt_q);
      ptr_q <= accept ? next_ptr : ptr_q;
      owner_q <= accept ? gnt_idx : owner_q;
      done_q <= expire ? (N_REQ'(1) << owner_q) : '0;
    end
  end
endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: cycle-by-cycle vector table plus a mid-count reset sequence
module tb_timer_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid;
  logic [19:0] req_delay;
  logic [3:0] req_ready;
  logic abort;
  logic [3:0] done;
  logic busy;
  logic [1:0] owner;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic rst;
    logic [3:0] v;
    logic [19:0] d;
    logic ab;
    logic [3:0] rdy;
    logic [3:0] dn;
    logic bz;
    logic [1:0] own;
  } vec_t;
  vec_t tbl[$];

  timer_scheduler dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_delay(req_delay),
    .req_ready(req_ready),
    .abort(abort),
    .done(done),
    .busy(busy),
    .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] dl(input logic [4:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  task automatic add(input logic rst, input logic [3:0] v, input logic [19:0] d, input logic ab,
                     input logic [3:0] rdy, input logic [3:0] dn, input logic bz, input logic [1:0] own,
                     input int n);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.ab = ab; r.rdy = rdy; r.dn = dn; r.bz = bz; r.own = own;
    repeat (n) tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [3:0] rdy, input logic [3:0] dn, input logic bz,
                     input logic [1:0] own);
    n_vec++;
    if ({req_ready, done, busy, owner} !== {rdy, dn, bz, own}) begin
      n_err++;
      $display("FAIL %s: got ready=%b done=%b busy=%b owner=%0d, want ready=%b done=%b busy=%b owner=%0d",
               nm, req_ready, done, busy, owner, rdy, dn, bz, own);
    end
  endtask

  initial begin
    logic [19:0] d3, da;
    d3 = dl(3, 3, 3, 3);
    da = dl(0, 10, 3, 0);
    // single request, requester 2, delay 5
    add(0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, 4'b0100, dl(0, 0, 5, 0), 0, 4'b0100, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1, 2, 5);
    add(1, 0, 0, 0, 0, 4'b0100, 0, 2, 1);
    add(1, 0, 0, 0, 0, 0, 0, 2, 1);
    // round robin, all valid, delay 3
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 4'b1111, d3, 0, 4'b0001, 0, 0, 0, 1);
    add(1, 4'b1110, d3, 0, 0, 0, 1, 0, 3);
    add(1, 4'b1110, d3, 0, 4'b0010, 4'b0001, 0, 0, 1);
    add(1, 4'b1100, d3, 0, 0, 0, 1, 1, 3);
    add(1, 4'b1100, d3, 0, 4'b0100, 4'b0010, 0, 1, 1);
    add(1, 4'b1000, d3, 0, 0, 0, 1, 2, 3);
    add(1, 4'b1000, d3, 0, 4'b1000, 4'b0100, 0, 2, 1);
    add(1, 0, d3, 0, 0, 0, 1, 3, 3);
    add(1, 0, d3, 0, 0, 4'b1000, 0, 3, 1);
    // delay 1 then delay 0 (full wrap)
    add(1, 4'b0001, dl(1, 0, 0, 0), 0, 4'b0001, 0, 0, 3, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 4'b0001, 0, 0, 1);
    add(1, 4'b0010, dl(0, 0, 0, 0), 0, 4'b0010, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1, 1, 32);
    add(1, 0, 0, 0, 0, 4'b0010, 0, 1, 1);
    // abort mid-count, requester 2 waiting
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 4'b0110, da, 0, 4'b0010, 0, 0, 0, 1);
    add(1, 4'b0100, da, 0, 0, 0, 1, 1, 3);
    add(1, 4'b0100, da, 1, 0, 0, 1, 1, 1);
    add(1, 4'b0100, da, 0, 4'b0100, 0, 0, 1, 1);
    add(1, 0, da, 0, 0, 0, 1, 2, 3);
    add(1, 0, da, 0, 0, 4'b0100, 0, 2, 1);
    // abort on the expiry edge
    add(1, 4'b1000, dl(0, 0, 0, 2), 0, 4'b1000, 0, 0, 2, 1);
    add(1, 0, 0, 0, 0, 0, 1, 3, 1);
    add(1, 0, 0, 1, 0, 0, 1, 3, 1);
    add(1, 0, 0, 0, 0, 0, 0, 3, 2);
    // abort while idle does not block an accept
    add(1, 4'b0001, dl(2, 0, 0, 0), 1, 4'b0001, 0, 0, 3, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0, 2);
    add(1, 0, 0, 0, 0, 4'b0001, 0, 0, 1);

    rst_n = 1'b1;
    req_valid = '0;
    req_delay = '0;
    abort = 1'b0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n = tbl[i].rst;
      req_valid = tbl[i].v;
      req_delay = tbl[i].d;
      abort = tbl[i].ab;
      @(negedge clk);
      chk($sformatf("row%0d", i), tbl[i].rdy, tbl[i].dn, tbl[i].bz, tbl[i].own);
    end

    // mid-count reset: requester 3 delay 20, reset during the count
    @(posedge clk);
    #1;
    req_valid = 4'b1000;
    req_delay = dl(0, 0, 0, 20);
    abort = 1'b0;
    @(negedge clk);
    chk("s6_accept", 4'b1000, 0, 0, 0);
    repeat (6) begin
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      chk("s6_busy", 0, 0, 1, 3);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("s6_reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 4'b1001;
    req_delay = dl(2, 0, 0, 20);
    @(negedge clk);
    chk("s6_prio", 4'b0001, 0, 0, 0);
    @(posedge clk);
    #1;
    req_valid = 4'b1000;
    @(negedge clk);
    chk("s6_cnt1", 0, 0, 1, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("s6_cnt0", 0, 0, 1, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("s6_done", 4'b1000, 4'b0001, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
